// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter with packet lock that drives the one-hot mux enable
// and captures the granted beat into a registered valid/ready output stage.
module mux_rr_arbiter #(
  parameter int WIDTH = 16,
  parameter int N     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid,
  input  logic [WIDTH-1:0] req_data [N-1:0],
  input  logic [N-1:0]     req_last,
  output logic [N-1:0]     req_ready,
  output logic [N-1:0]     en,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [N-1:0]     out_src,
  input  logic             out_ready
);

  localparam int unsigned NU = N;
  localparam int          PW = $clog2(N);

  typedef enum logic {ARB, LOCK} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    ptr, ptr_nxt;
  logic [PW-1:0]    owner, owner_nxt;
  logic [PW-1:0]    grant, rr_idx;
  logic             found;
  logic             slot_free;
  logic             xfer;
  logic             grant_last;
  logic [WIDTH-1:0] mux_data;

  function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] i);
    return (32'(i) == NU - 1) ? '0 : i + PW'(1);
  endfunction

  // Scan from ptr upward, wrapping, and take the first valid requester.
  always_comb begin
    grant  = '0;
    rr_idx = '0;
    found  = 1'b0;
    if (state == LOCK) begin
      grant = owner;
      found = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NU; k++) begin
        rr_idx = PW'((32'(ptr) + k) % NU);
        if (!found && req_valid[rr_idx]) begin
          found = 1'b1;
          grant = rr_idx;
        end
      end
    end
  end

  assign slot_free = !out_valid || out_ready;

  // rst_n gating keeps en/req_ready low while reset is held.
  always_comb begin
    en        = '0;
    req_ready = '0;
    if (rst_n && found) begin
      req_ready[grant] = slot_free;
      en[grant]        = (state == LOCK) ? req_valid[grant] : 1'b1;
    end
  end

  assign xfer       = |(req_valid & req_ready);
  assign grant_last = req_last[grant];

  always_comb begin
    mux_data = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      if (en[PW'(i)]) mux_data = mux_data | req_data[PW'(i)];
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    case (state)
      ARB: begin
        if (xfer) begin
          if (grant_last) begin
            ptr_nxt = inc_mod(grant);
          end else begin
            owner_nxt = grant;
            state_nxt = LOCK;
          end
        end
      end
      LOCK: begin
        if (xfer && grant_last) begin
          ptr_nxt   = inc_mod(owner);
          state_nxt = ARB;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_last  <= grant_last;
      out_src   <= en;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed vector table, reset
// sequence, and randomized traffic compared against a cycle reference model.
module tb_mux_rr_arbiter;

  localparam int N = 3;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [W-1:0]  req_data [N-1:0];
  logic [N-1:0]  req_last;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  en;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic [N-1:0]  out_src;
  logic          out_ready;

  int errs   = 0;
  int checks = 0;

  mux_rr_arbiter #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .en(en),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_src(out_src), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] v;
    logic [N-1:0] l;
    logic         ordy;
    logic [N-1:0] e_en;
    logic [N-1:0] e_rdy;
    logic         e_ov;
    logic [W-1:0] e_od;
    logic [N-1:0] e_os;
  } row_t;

  row_t rows [26];

  function automatic row_t mk(input logic [N-1:0] v, input logic [N-1:0] l,
                              input logic ordy, input logic [N-1:0] e_en,
                              input logic [N-1:0] e_rdy, input logic e_ov,
                              input logic [W-1:0] e_od, input logic [N-1:0] e_os);
    row_t r;
    r.v = v; r.l = l; r.ordy = ordy; r.e_en = e_en; r.e_rdy = e_rdy;
    r.e_ov = e_ov; r.e_od = e_od; r.e_os = e_os;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: priority list ptr, ptr+1, ... mod N; lock held by owner until last.
  int           m_ptr, m_owner, m_g;
  bit           m_lock, m_xfer;
  logic         m_ov, m_ol;
  logic [W-1:0] m_od;
  logic [N-1:0] m_os, e_en, e_rdy;

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_lock = 0;
    m_ov = 0; m_od = '0; m_ol = 0; m_os = '0;
  endtask

  task automatic model_comb();
    bit fnd = 0;
    int g   = 0;
    bit sf  = !m_ov || out_ready;
    e_en  = '0;
    e_rdy = '0;
    if (m_lock) begin
      g = m_owner;
      fnd = 1;
      if (((req_valid >> g) & 1) != 0) e_en = N'(1 << g);
    end else begin
      for (int k = 0; k < N; k++) begin
        int j = (m_ptr + k) % N;
        if (!fnd && ((req_valid >> j) & 1) != 0) begin
          fnd = 1;
          g = j;
          e_en = N'(1 << j);
        end
      end
    end
    if (fnd && sf) e_rdy = N'(1 << g);
    m_g = g;
    m_xfer = fnd && sf && (((req_valid >> g) & 1) != 0);
  endtask

  task automatic model_next();
    if (m_xfer) begin
      bit lst = ((req_last >> m_g) & 1) != 0;
      m_ov = 1;
      m_od = req_data[m_g];
      m_ol = lst;
      m_os = N'(1 << m_g);
      if (lst) begin
        m_ptr = (m_g + 1) % N;
        m_lock = 0;
      end else begin
        m_lock = 1;
        m_owner = m_g;
      end
    end else if (out_ready) begin
      m_ov = 0;
    end
  endtask

  // Called at posedge+1; leaves time at posedge+4 after checking.
  task automatic drive_check(input logic [N-1:0] v, input logic [N-1:0] l, input logic ordy);
    req_valid = v;
    req_last  = l;
    out_ready = ordy;
    #3;
    model_comb();
    chk("en", 32'(en), 32'(e_en));
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data", 32'(out_data), 32'(m_od));
    chk("out_last", 32'(out_last), 32'(m_ol));
    chk("out_src", 32'(out_src), 32'(m_os));
    chk("en_onehot", 32'($countones(en) <= 1), 32'(1));
    chk("src_onehot", 32'($countones(out_src) <= 1), 32'(1));
  endtask

  task automatic advance();
    model_next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_last = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) req_data[i] = 16'hA000 + 16'(i);
    model_reset();

    //           v       l       rdy   en      ready   ov    data      src
    rows[0]  = mk(3'b111, 3'b111, 1'b1, 3'b001, 3'b001, 1'b0, 16'h0000, 3'b000);
    rows[1]  = mk(3'b111, 3'b111, 1'b1, 3'b010, 3'b010, 1'b1, 16'hA000, 3'b001);
    rows[2]  = mk(3'b111, 3'b111, 1'b1, 3'b100, 3'b100, 1'b1, 16'hA001, 3'b010);
    rows[3]  = mk(3'b111, 3'b111, 1'b1, 3'b001, 3'b001, 1'b1, 16'hA002, 3'b100);
    rows[4]  = mk(3'b111, 3'b111, 1'b0, 3'b010, 3'b000, 1'b1, 16'hA000, 3'b001);
    rows[5]  = mk(3'b111, 3'b111, 1'b0, 3'b010, 3'b000, 1'b1, 16'hA000, 3'b001);
    rows[6]  = mk(3'b111, 3'b111, 1'b0, 3'b010, 3'b000, 1'b1, 16'hA000, 3'b001);
    rows[7]  = mk(3'b111, 3'b111, 1'b1, 3'b010, 3'b010, 1'b1, 16'hA000, 3'b001);
    rows[8]  = mk(3'b111, 3'b111, 1'b1, 3'b100, 3'b100, 1'b1, 16'hA001, 3'b010);
    rows[9]  = mk(3'b001, 3'b001, 1'b1, 3'b001, 3'b001, 1'b1, 16'hA002, 3'b100);
    rows[10] = mk(3'b111, 3'b101, 1'b1, 3'b010, 3'b010, 1'b1, 16'hA000, 3'b001);
    rows[11] = mk(3'b111, 3'b101, 1'b1, 3'b010, 3'b010, 1'b1, 16'hA001, 3'b010);
    rows[12] = mk(3'b111, 3'b111, 1'b1, 3'b010, 3'b010, 1'b1, 16'hA001, 3'b010);
    rows[13] = mk(3'b111, 3'b111, 1'b1, 3'b100, 3'b100, 1'b1, 16'hA001, 3'b010);
    rows[14] = mk(3'b111, 3'b111, 1'b1, 3'b001, 3'b001, 1'b1, 16'hA002, 3'b100);
    rows[15] = mk(3'b010, 3'b111, 1'b1, 3'b010, 3'b010, 1'b1, 16'hA000, 3'b001);
    rows[16] = mk(3'b011, 3'b110, 1'b1, 3'b001, 3'b001, 1'b1, 16'hA001, 3'b010);
    rows[17] = mk(3'b010, 3'b110, 1'b1, 3'b000, 3'b001, 1'b1, 16'hA000, 3'b001);
    rows[18] = mk(3'b010, 3'b110, 1'b1, 3'b000, 3'b001, 1'b0, 16'hA000, 3'b001);
    rows[19] = mk(3'b011, 3'b111, 1'b1, 3'b001, 3'b001, 1'b0, 16'hA000, 3'b001);
    rows[20] = mk(3'b010, 3'b111, 1'b1, 3'b010, 3'b010, 1'b1, 16'hA000, 3'b001);
    rows[21] = mk(3'b100, 3'b111, 1'b1, 3'b100, 3'b100, 1'b1, 16'hA001, 3'b010);
    rows[22] = mk(3'b100, 3'b111, 1'b1, 3'b100, 3'b100, 1'b1, 16'hA002, 3'b100);
    rows[23] = mk(3'b100, 3'b111, 1'b1, 3'b100, 3'b100, 1'b1, 16'hA002, 3'b100);
    rows[24] = mk(3'b000, 3'b111, 1'b1, 3'b000, 3'b000, 1'b1, 16'hA002, 3'b100);
    rows[25] = mk(3'b000, 3'b111, 1'b1, 3'b000, 3'b000, 1'b0, 16'hA002, 3'b100);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_en", 32'(en), 32'(0));
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    rst_n = 1'b1;

    for (int r = 0; r < 26; r++) begin
      drive_check(rows[r].v, rows[r].l, rows[r].ordy);
      chk($sformatf("row%0d_en", r), 32'(en), 32'(rows[r].e_en));
      chk($sformatf("row%0d_ready", r), 32'(req_ready), 32'(rows[r].e_rdy));
      chk($sformatf("row%0d_ov", r), 32'(out_valid), 32'(rows[r].e_ov));
      chk($sformatf("row%0d_od", r), 32'(out_data), 32'(rows[r].e_od));
      chk($sformatf("row%0d_os", r), 32'(out_src), 32'(rows[r].e_os));
      advance();
    end

    // Reset asserted mid-packet: outputs and handshakes drop without a clock.
    drive_check(3'b111, 3'b110, 1'b1);
    advance();
    req_valid = 3'b111;
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_req_ready", 32'(req_ready), 32'(0));
    chk("midrst_en", 32'(en), 32'(0));
    chk("midrst_out_data", 32'(out_data), 32'(0));
    chk("midrst_out_src", 32'(out_src), 32'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_check(3'b111, 3'b111, 1'b1);
    chk("post_rst_first_grant", 32'(en), 32'(3'b001));
    advance();

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) req_data[i] = 16'($urandom);
      drive_check(N'($urandom), N'($urandom | $urandom), ($urandom_range(0, 3) != 0));
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and output register that shares the 16-bit one-hot mux datapath between N requesters. Each cycle it picks at most one valid requester, drives the one-hot enable for that source and captures the selected data into a registered valid/ready output stage. Multi-beat packets (terminated by `last`) hold the grant until complete. The block sits directly in front of the ALU operand path and replaces ad-hoc enable generation for the mux.

## Interface
- `WIDTH`, 16, data width per requester.
- `N`, 3, number of requesters; legal range 2..8.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input N: per-requester valid.
- `req_data` input WIDTH x N (unpacked array `[N-1:0]`): per-requester data.
- `req_last` input N: marks the final beat of a packet; single-beat packets assert it on every beat.
- `req_ready` output N: per-requester ready; at most one bit high.
- `en` output N: one-hot mux enable for the current grant; all zero when nothing is granted.
- `out_valid` output 1: registered output valid.
- `out_data` output WIDTH: registered output data.
- `out_last` output 1: registered copy of the accepted beat's `req_last`.
- `out_src` output N: registered one-hot source of the current `out_data`.
- `out_ready` input 1: downstream ready.

## Operation
- Reset is asynchronous: `rst_n` low forces `out_valid`=0, `out_data`=0, `out_last`=0, `out_src`=0, state=ARB and ptr=0. `req_ready` and `en` are 0 while `rst_n` is low.
- `slot_free = !out_valid || out_ready`. A beat transfers from requester i when `req_valid[i] && req_ready[i]`.
- ptr (0..N-1) is the highest-priority index. Priority order is ptr, ptr+1, …, wrapping mod N.
- State ARB:
  - grant = the first i in priority order with `req_valid[i]`; `en` = one-hot(grant), or 0 if no requester is valid.
  - `req_ready[grant] = slot_free`.
  - On a transfer with `req_last`=1: ptr <= grant+1 mod N; stay in ARB.
  - On a transfer with `req_last`=0: owner <= grant; go to LOCK (ptr unchanged).
- State LOCK:
  - grant = owner regardless of `req_valid`. `en` = one-hot(owner) while `req_valid[owner]`, else 0. `req_ready[owner] = slot_free`. All other `req_ready` bits are 0.
  - On a transfer with `req_last`=1: ptr <= owner+1 mod N; go to ARB.
- On any transfer: `out_valid` <= 1; `out_data` <= OR of `req_data[i]` masked by `en` (one-hot, so exactly the granted data); `out_last` <= `req_last[grant]`; `out_src` <= `en`.
- When `out_valid && out_ready` with no new transfer: `out_valid` <= 0. Data, last and src hold their last values.
- When not accepted, the `out_*` registers hold stable (no change while `out_valid && !out_ready`).
- `en` and `req_ready` are combinational from state, ptr, `req_valid` and `out_*`. Neither depends combinationally on `req_data`.

## Timing
- Latency: a beat accepted in cycle t appears on `out_*` in cycle t+1.
- Throughput: 1 beat/cycle when `out_ready` is held 1. Drain and refill occur in the same cycle.
- Back-pressure: `out_ready`=0 with `out_valid`=1 deasserts every `req_ready` in the same cycle.
- Fairness: with all N valid and single-beat packets, grants rotate 0,1,…,N-1,0… with no repeats inside N cycles.
- ptr advances only on packet completion. An idle cycle and a LOCK-state beat leave ptr unchanged.
- Reset mid-packet: the state and the output beat are discarded and arbitration restarts at ptr=0.
- `out_src` is never multi-hot. `en` is never multi-hot.

## Test plan
- Reset: drive `rst_n`=0 mid-transfer with `req_valid`=3'b111 -> `out_valid`=0, `req_ready`=0 and `en`=0 immediately. After release, the first grant goes to index 0.
- Round-robin: all valid, all `last`=1, `out_ready`=1, data 0xA000+i -> `out_data` sequence A000, A001, A002, A000 starting from cycle 2, with `out_src` 001, 010, 100, 001.
- Back-pressure: hold `out_ready`=0 for 3 cycles with `out_valid`=1 -> `out_data` stable, `req_ready`=0. On release, one beat/cycle resumes with no data lost.
- Packet lock: requester 1 sends 3 beats (`last` on beat 3) while 0 and 2 are valid -> three consecutive `out_src`=010. Next grant is requester 2, then 0.
- Lock with gap: owner 0 drops `req_valid` for 2 cycles mid-packet while 1 is valid -> `en`=0 and `req_ready[1]`=0 during the gap. The packet completes from 0 before 1 is granted.
- Sparse: only requester 2 valid, single beats -> repeated grant to 2 every cycle. ptr wraps to 0 after each beat.
